// File: rtl/mhp_link_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mhp_link_ctrl: PING/ACK/LINK handshake controller on the MHP byte interface |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module mhp_link_ctrl #(
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] MY_ADDR       = 16'h0000,
  parameter int                PAYLOAD_BYTES = 4,
  parameter logic [6:0]        PING_TYPE     = 7'h03,
  parameter logic [6:0]        ACK_TYPE      = 7'h04,
  parameter logic [6:0]        LINK_TYPE     = 7'h05,
  parameter int                TIMEOUT       = 1000,
  parameter int                MAX_RETRY     = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic [8*PAYLOAD_BYTES-1:0] i_payload,
  input  logic [7:0]                 i_rdata,
  input  logic                       i_rready,
  output logic                       o_rreq,
  output logic [7:0]                 o_wdata,
  input  logic                       i_wready,
  output logic                       o_wvalid,
  output logic                       o_link,
  output logic                       o_busy,
  output logic                       o_fail
);

  localparam int c_AB    = ADDR_W / 8;
  localparam int c_HDR   = 2 * c_AB + 1;
  localparam int c_TXN   = 2 * c_AB + 2 + PAYLOAD_BYTES;
  localparam int c_CNT_W = $clog2(c_HDR + 1);
  localparam int c_IDX_W = $clog2(c_TXN + 1);
  localparam int c_TMR_W = $clog2(TIMEOUT + 1);
  localparam int c_RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int c_PL_W  = (PAYLOAD_BYTES > 0) ? 8 * PAYLOAD_BYTES : 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RX_PING   = 3'd1,
    S_TX_ACK    = 3'd2,
    S_WAIT_LINK = 3'd3,
    S_RX_LINK   = 3'd4,
    S_LINK      = 3'd5
  } state_t;

  state_t               r_state;
  logic                 r_inflight;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]    r_dst;
  logic [ADDR_W-1:0]    r_src;
  logic [6:0]           r_type;
  logic [ADDR_W-1:0]    r_peer;
  logic [c_PL_W-1:0]    r_payload;
  logic [c_IDX_W-1:0]   r_tx_idx;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_RT_W-1:0]    r_retry;

  logic w_rx_end;
  logic w_hdr_ok;
  logic w_dst_ok;
  logic w_tmo;
  logic w_accept;
  logic w_last;

  // ACK byte at position idx; peer is passed in so the first byte can use the
  // source address being captured on the same edge
  function automatic logic [7:0] tx_byte(input logic [c_IDX_W-1:0] idx,
                                         input logic [ADDR_W-1:0]  peer,
                                         input logic [c_PL_W-1:0]  pl);
    int k;
    k = int'(idx);
    tx_byte = 8'h00;
    if (k < c_AB)                tx_byte = 8'(peer >> (8 * (c_AB - 1 - k)));
    else if (k < 2 * c_AB)       tx_byte = 8'(MY_ADDR >> (8 * (2 * c_AB - 1 - k)));
    else if (k == 2 * c_AB)      tx_byte = {1'b1, ACK_TYPE};
    else if (k == 2 * c_AB + 1)  tx_byte = 8'(PAYLOAD_BYTES);
    else                         tx_byte = 8'(pl >> (8 * (c_TXN - 1 - k)));
  endfunction

  assign o_rreq   = i_rready && (r_state == S_RX_PING || r_state == S_RX_LINK ||
                                 r_state == S_LINK);
  assign o_busy   = (r_state == S_RX_PING) || (r_state == S_TX_ACK) ||
                    (r_state == S_WAIT_LINK) || (r_state == S_RX_LINK);
  assign o_link   = (r_state == S_LINK);

  assign w_rx_end = (r_state == S_RX_PING || r_state == S_RX_LINK) &&
                    !i_rready && !r_inflight;
  assign w_hdr_ok = (r_cnt == c_CNT_W'(c_HDR));
  assign w_dst_ok = (r_dst == MY_ADDR) || (&r_dst);
  assign w_tmo    = (r_timer >= c_TMR_W'(TIMEOUT - 1));
  assign w_accept = o_wvalid && i_wready;
  assign w_last   = (r_tx_idx == c_IDX_W'(c_TXN - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_dst      <= '0;
      r_src      <= '0;
      r_type     <= '0;
      r_peer     <= '0;
      r_payload  <= '0;
      r_tx_idx   <= '0;
      r_timer    <= '0;
      r_retry    <= '0;
      o_wvalid   <= 1'b0;
      o_wdata    <= 8'h00;
      o_fail     <= 1'b0;
    end else begin
      r_inflight <= o_rreq;
      o_fail     <= 1'b0;

      // Header bytes land one cycle after their pop; trailing bytes are dropped
      if (r_inflight && r_cnt != c_CNT_W'(c_HDR)) begin
        if (r_cnt < c_CNT_W'(c_AB))
          r_dst <= (r_dst << 8) | ADDR_W'(i_rdata);
        else if (r_cnt < c_CNT_W'(2 * c_AB))
          r_src <= (r_src << 8) | ADDR_W'(i_rdata);
        else
          r_type <= i_rdata[6:0];
        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == S_WAIT_LINK || r_state == S_RX_LINK) &&
          r_timer != c_TMR_W'(TIMEOUT))
        r_timer <= r_timer + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_enable && i_rready) begin
            r_state <= S_RX_PING;
            r_cnt   <= '0;
          end
        end

        S_RX_PING: begin
          if (w_rx_end) begin
            if (i_enable && w_hdr_ok && w_dst_ok && r_type == PING_TYPE) begin
              r_peer    <= r_src;
              r_retry   <= '0;
              r_payload <= c_PL_W'(i_payload);
              r_tx_idx  <= '0;
              o_wvalid  <= 1'b1;
              o_wdata   <= tx_byte(c_IDX_W'(0), r_src, r_payload);
              r_state   <= S_TX_ACK;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_TX_ACK: begin
          if (w_accept) begin
            if (w_last || !i_enable) begin
              o_wvalid <= 1'b0;
              r_timer  <= '0;
              r_state  <= i_enable ? S_WAIT_LINK : S_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
              o_wdata  <= tx_byte(r_tx_idx + 1'b1, r_peer, r_payload);
            end
          end
        end

        S_WAIT_LINK: begin
          if (!i_enable) begin
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            if (r_retry < c_RT_W'(MAX_RETRY)) begin
              r_retry   <= r_retry + 1'b1;
              r_payload <= c_PL_W'(i_payload);
              r_tx_idx  <= '0;
              o_wvalid  <= 1'b1;
              o_wdata   <= tx_byte(c_IDX_W'(0), r_peer, r_payload);
              r_state   <= S_TX_ACK;
            end else begin
              o_fail  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (i_rready) begin
            r_cnt   <= '0;
            r_state <= S_RX_LINK;
          end
        end

        S_RX_LINK: begin
          // A timeout reached here is serviced back in WAIT_LINK (timer >= limit)
          if (w_rx_end) begin
            if (!i_enable)
              r_state <= S_IDLE;
            else if (w_hdr_ok && r_src == r_peer && r_type == LINK_TYPE &&
                     r_dst == MY_ADDR)
              r_state <= S_LINK;
            else
              r_state <= S_WAIT_LINK;
          end
        end

        S_LINK: begin
          if (!i_enable) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mhp_link_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mhp_link_ctrl: scoreboard bench for the PING/ACK/LINK handshake          |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_mhp_link_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] payload;
  logic [7:0]  rdata;
  logic        rready;
  logic        rreq;
  logic [7:0]  wdata;
  logic        wready;
  logic        wvalid;
  logic        link;
  logic        busy;
  logic        fail;

  int checks = 0;
  int failures = 0;

  logic [7:0] fr[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         gaps[$];
  int         hold_err = 0, fail_cnt = 0, fail_long = 0, gap_cnt = 0, rises = 0;
  logic       prev_hold = 1'b0, prev_wv = 1'b0, prev_fail = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  int         wr_mode = 0, wr_k = 0, drained = 0;

  always #5 clk = ~clk;

  mhp_link_ctrl #(
    .ADDR_W(16), .MY_ADDR(16'h0000), .PAYLOAD_BYTES(4),
    .PING_TYPE(7'h03), .ACK_TYPE(7'h04), .LINK_TYPE(7'h05),
    .TIMEOUT(50), .MAX_RETRY(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_payload(payload),
    .i_rdata(rdata), .i_rready(rready), .o_rreq(rreq), .o_wdata(wdata),
    .i_wready(wready), .o_wvalid(wvalid), .o_link(link), .o_busy(busy),
    .o_fail(fail)
  );

  // TX sink: always ready, or the repeating 1-0-0-1 pattern
  initial begin
    wready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (wr_mode == 1) begin
        case (wr_k % 4)
          1, 2:    wready = 1'b0;
          default: wready = 1'b1;
        endcase
        wr_k++;
      end else begin
        wready = 1'b1;
      end
    end
  end

  // Observer: accepted bytes, hold stability, gap lengths, fail pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0; prev_wv = 1'b0; prev_fail = 1'b0;
    end else begin
      if (prev_hold && (!wvalid || wdata !== prev_byte)) hold_err++;
      if (wvalid && !prev_wv) begin gaps.push_back(gap_cnt); rises++; end
      if (wvalid && wready) begin got_q.push_back(wdata); gap_cnt = 0; end
      else if (busy && !wvalid) gap_cnt++;
      if (fail) begin fail_cnt++; if (prev_fail) fail_long++; end
      prev_hold = wvalid && !wready;
      prev_byte = wdata;
      prev_wv   = wvalid;
      prev_fail = fail;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic send_frame();
    int   idx = 0;
    int   guard = 0;
    logic pop;
    @(negedge clk);
    rready = (fr.size() > 0);
    while (idx < fr.size() && guard < 200) begin
      #1 pop = rreq;
      @(posedge clk); #1;
      if (pop) begin rdata = fr[idx]; idx++; end
      rready = (idx < fr.size());
      @(negedge clk);
      guard++;
    end
    rready  = 1'b0;
    drained = idx;
  endtask

  task automatic push_ack();
    logic [7:0] hdr[6];
    hdr = '{8'h00, 8'h07, 8'h00, 8'h00, 8'h84, 8'h04};
    foreach (hdr[i]) exp_q.push_back(hdr[i]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(payload[8*i +: 8]);
  endtask

  task automatic wait_bytes(input int n, input int bound, output bit ok);
    int t = 0;
    while (got_q.size() < n && t < bound) begin tick(); t++; end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; rready = 1'b0; rdata = 8'h00;
    payload = 32'hA1B2C3D4;
    repeat (3) tick();
    checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got=%b exp=0", wvalid); end
    checks++; if (wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", wdata); end
    checks++; if (link !== 1'b0) begin failures++; $display("FAIL reset_link got=%b exp=0", link); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%b exp=0", fail); end
    checks++; if (rreq !== 1'b0) begin failures++; $display("FAIL reset_rreq got=%b exp=0", rreq); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_handshake();
    bit ok;
    logic [7:0] a, e;
    enable = 1'b1;
    got_q.delete(); exp_q.delete();
    push_ack();
    fr = '{8'hFF, 8'hFF, 8'h00, 8'h07, 8'h03};
    send_frame();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hs_busy_rx got=%b exp=1", busy); end
    tick();
    checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL hs_wvalid_end_cycle got=%b exp=0", wvalid); end
    tick();
    checks++; if (wvalid !== 1'b1) begin failures++; $display("FAIL hs_first_byte_latency got=%b exp=1", wvalid); end
    wait_bytes(10, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL hs_ack_timeout got=%0d exp=10 bytes", got_q.size()); end
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin failures++; $display("FAIL hs_ack_byte[%0d] got=%h exp=%h", i, a, e); end
    end
    tick();
    checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL hs_wvalid_drop got=%b exp=0", wvalid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hs_busy_wait got=%b exp=1", busy); end
    fr = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h05};
    send_frame();
    tick();
    checks++; if (link !== 1'b0) begin failures++; $display("FAIL hs_link_early got=%b exp=0", link); end
    tick();
    checks++; if (link !== 1'b1) begin failures++; $display("FAIL hs_link_rise got=%b exp=1", link); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hs_busy_link got=%b exp=0", busy); end
    checks++; if (fail_cnt !== 0) begin failures++; $display("FAIL hs_no_fail got=%0d exp=0", fail_cnt); end
    enable = 1'b0;
    tick();
    checks++; if (link !== 1'b0) begin failures++; $display("FAIL hs_link_drop got=%b exp=0", link); end
    enable = 1'b1;
  endtask

  task automatic test_foreign();
    int r0;
    for (int f = 0; f < 3; f++) begin
      case (f)
        0:       fr = '{8'h00, 8'h09, 8'h00, 8'h07, 8'h03};
        1:       fr = '{8'hFF, 8'hFF, 8'h00, 8'h07, 8'h02};
        default: fr = '{8'hFF, 8'hFF};
      endcase
      r0 = rises;
      send_frame();
      repeat (4) tick();
      checks++; if (drained !== fr.size()) begin failures++; $display("FAIL fg_drain[%0d] got=%0d exp=%0d", f, drained, fr.size()); end
      checks++; if (rises !== r0) begin failures++; $display("FAIL fg_no_ack[%0d] got=%0d exp=%0d", f, rises, r0); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fg_busy[%0d] got=%b exp=0", f, busy); end
    end
  endtask

  task automatic test_retry();
    int f0, t;
    logic [7:0] a, e;
    got_q.delete(); exp_q.delete(); gaps.delete();
    repeat (3) push_ack();
    f0 = fail_cnt;
    fr = '{8'hFF, 8'hFF, 8'h00, 8'h07, 8'h03};
    send_frame();
    t = 0;
    while (fail_cnt == f0 && t < 500) begin tick(); t++; end
    checks++; if (fail_cnt == f0) begin failures++; $display("FAIL rt_fail_timeout got=%0d exp=%0d", fail_cnt, f0 + 1); end
    for (int i = 0; i < 30; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin failures++; $display("FAIL rt_ack_byte[%0d] got=%h exp=%h", i, a, e); end
    end
    checks++; if (gaps.size() !== 3) begin failures++; $display("FAIL rt_ack_count got=%0d exp=3", gaps.size()); end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (i >= gaps.size() || gaps[i] !== 50) begin
        failures++; $display("FAIL rt_gap[%0d] got=%0d exp=50", i, (i < gaps.size()) ? gaps[i] : -1);
      end
    end
    repeat (3) tick();
    checks++; if (fail_cnt !== f0 + 1) begin failures++; $display("FAIL rt_fail_count got=%0d exp=%0d", fail_cnt, f0 + 1); end
    checks++; if (fail_long !== 0) begin failures++; $display("FAIL rt_fail_pulse got=%0d exp=0", fail_long); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rt_busy_idle got=%b exp=0", busy); end
  endtask

  task automatic test_wready_stall();
    bit ok;
    int h0;
    logic [7:0] a, e;
    got_q.delete(); exp_q.delete();
    push_ack();
    h0 = hold_err;
    wr_mode = 1;
    fr = '{8'hFF, 8'hFF, 8'h00, 8'h07, 8'h03};
    send_frame();
    wait_bytes(10, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL st_ack_timeout got=%0d exp=10 bytes", got_q.size()); end
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin failures++; $display("FAIL st_ack_byte[%0d] got=%h exp=%h", i, a, e); end
    end
    repeat (4) tick();
    wr_mode = 0;
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL st_extra_bytes got=%0d exp=0", got_q.size()); end
    checks++; if (hold_err !== h0) begin failures++; $display("FAIL st_hold_stable got=%0d exp=%0d", hold_err, h0); end
  endtask

  task automatic test_link_wrong_src();
    bit ok;
    logic [7:0] a, e;
    gaps.delete(); got_q.delete(); exp_q.delete();
    fr = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h05};
    send_frame();
    tick(); tick();
    checks++; if (link !== 1'b0) begin failures++; $display("FAIL ws_link got=%b exp=0", link); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ws_busy got=%b exp=1", busy); end
    push_ack();
    wait_bytes(10, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ws_retry_timeout got=%0d exp=10 bytes", got_q.size()); end
    checks++;
    if (gaps.size() < 1 || gaps[0] !== 50) begin
      failures++; $display("FAIL ws_timer_kept got=%0d exp=50", (gaps.size() > 0) ? gaps[0] : -1);
    end
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin failures++; $display("FAIL ws_ack_byte[%0d] got=%h exp=%h", i, a, e); end
    end
    fr = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h05};
    send_frame();
    tick(); tick();
    checks++; if (link !== 1'b1) begin failures++; $display("FAIL ws_link_ok got=%b exp=1", link); end
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] a, e;
    got_q.delete(); exp_q.delete();
    fr = '{8'hFF, 8'hFF, 8'h00, 8'h07, 8'h03};
    send_frame();
    wait_bytes(2, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rm_pre_timeout got=%0d exp=2 bytes", got_q.size()); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (wvalid !== 1'b0) begin failures++; $display("FAIL rm_wvalid got=%b exp=0", wvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
    checks++; if (link !== 1'b0 || fail !== 1'b0 || rreq !== 1'b0) begin
      failures++; $display("FAIL rm_other_outputs got=%b%b%b exp=000", link, fail, rreq);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    got_q.delete(); exp_q.delete();
    push_ack();
    send_frame();
    wait_bytes(10, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rm_ack_timeout got=%0d exp=10 bytes", got_q.size()); end
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (a !== e) begin failures++; $display("FAIL rm_ack_byte[%0d] got=%h exp=%h", i, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_foreign();
    test_retry();
    test_wready_stall();
    test_link_wrong_src();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
